// File: rtl/mem_rd_arbiter.sv
// Two-requester (instruction fetch / load) read arbiter onto one downstream port.
// One transaction in flight at a time, with fixed or round-robin priority and an optional watchdog.
module mem_rd_arbiter #(
  parameter int XLEN      = 32,
  parameter int AW        = 32,
  parameter int DATA_PRIO = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [1:0]      d_size,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            m_req,
  output logic [AW-1:0]   m_addr,
  output logic [1:0]      m_size,
  input  logic            m_ack,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_err,
  output logic [1:0]      grant,
  output logic            busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [1:0]      m_size_q, m_size_d;
  logic            last_d_q, last_d_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic in_busy;
  logic own_i;
  logic own_d;
  logic timeout_hit;
  logic finish;
  logic pick_d;

  assign in_busy = (state_q != ST_IDLE);
  assign own_i   = (state_q == ST_BUSY_I);
  assign own_d   = (state_q == ST_BUSY_D);

  // A real acknowledge in the last allowed cycle beats the watchdog.
  assign timeout_hit = (TIMEOUT != 0) && in_busy && (cnt_q == TO_LAST) && !m_ack;
  assign finish      = in_busy && (m_ack || timeout_hit);

  // Round-robin: on a tie, D wins only if I was granted last.
  assign pick_d = (DATA_PRIO != 0) ? d_req : (d_req && (!i_req || !last_d_q));

  always_comb begin
    state_d  = state_q;
    m_addr_d = m_addr_q;
    m_size_d = m_size_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (i_req || d_req) begin
          last_d_d = pick_d;
          if (pick_d) begin
            state_d  = ST_BUSY_D;
            m_addr_d = d_addr;
            m_size_d = d_size;
          end else begin
            state_d  = ST_BUSY_I;
            m_addr_d = i_addr;
            m_size_d = 2'd2;
          end
        end
      end
      default: begin
        if (finish) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      m_addr_q <= '0;
      m_size_q <= '0;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_addr_q <= m_addr_d;
      m_size_q <= m_size_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_req  = in_busy;
  assign busy   = in_busy;
  assign grant  = {own_d, own_i};
  assign m_addr = m_addr_q;
  assign m_size = m_size_q;

  // Completion is combinational on m_ack; data is zeroed unless a real ack is passed through.
  assign i_ack   = own_i && (m_ack || timeout_hit);
  assign i_rdata = (own_i && m_ack) ? m_rdata : '0;
  assign i_err   = own_i && (m_ack ? m_err : timeout_hit);

  assign d_ack   = own_d && (m_ack || timeout_hit);
  assign d_rdata = (own_d && m_ack) ? m_rdata : '0;
  assign d_err   = own_d && (m_ack ? m_err : timeout_hit);

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares one downstream read port between the core's instruction-fetch requester (I) and its load requester (D), for a single-ported memory/cache.
- Sits between the core's read buses and the memory subsystem.
- Serialises requests, one outstanding transaction at a time.
- Selects with fixed or round-robin priority; a per-transaction watchdog aborts reads whose slave never acknowledges.

Parameters:
- XLEN, 32, data width of rdata.
- AW, 32, address width.
- DATA_PRIO, 1, 1 = D always wins ties; 0 = round-robin between I and D.
- TIMEOUT, 255, cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request, held until i_ack
- i_addr  in  AW  instruction address, stable while i_req
- i_ack  out  1  one-cycle completion pulse to I
- i_rdata  out  XLEN  read data, valid with i_ack
- i_err  out  1  error flag, valid with i_ack
- d_req  in  1  data read request, held until d_ack
- d_addr  in  AW  data address, stable while d_req
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_ack  out  1  one-cycle completion pulse to D
- d_rdata  out  XLEN  read data, valid with d_ack
- d_err  out  1  error flag, valid with d_ack
- m_req  out  1  downstream request
- m_addr  out  AW  downstream address (registered)
- m_size  out  2  downstream size (registered; 2 for I)
- m_ack  in  1  downstream completion pulse
- m_rdata  in  XLEN  downstream data, valid with m_ack
- m_err  in  1  downstream error, valid with m_ack
- grant  out  2  one-hot owner {D,I}; 0 when idle
- busy  out  1  transaction in flight

Behaviour:
- Reset (async, any state):
  - FSM = IDLE; all outputs 0, including grant and busy.
  - m_addr and m_size = 0; round-robin pointer = "I last"; watchdog counter = 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If i_req or d_req, select a winner, latch its addr/size into m_addr/m_size, and go to BUSY_x.
  - m_req, grant and busy assert the next cycle (1-cycle request latency).
- Selection:
  - DATA_PRIO=1: D wins whenever d_req=1.
  - DATA_PRIO=0: on a tie, grant the requester not granted last; a lone requester always wins.
  - The pointer updates only on grant.
- BUSY_x:
  - m_req=1; m_addr/m_size held constant.
  - The counter increments each cycle from 0.
- m_ack=1 in BUSY_x:
  - x_ack=1 in the same cycle (combinational).
  - x_rdata=m_rdata, x_err=m_err.
  - Next state IDLE; m_req drops next cycle.
- Timeout, counter == TIMEOUT-1 and no m_ack:
  - x_ack=1, x_err=1, x_rdata=0.
  - Go to IDLE; m_req drops.
  - m_ack coincident with the timeout cycle wins: a normal completion.
- m_ack in IDLE (stray, late after timeout, or post-reset) is ignored; no ack is generated.
- Back-to-back: the cycle after completion is IDLE, so minimum spacing is 1 idle cycle between m_req pulses.
  - A request held across completion is re-arbitrated in that IDLE cycle.
- Requester deasserting req before its ack is a protocol violation: the transaction still completes and the ack is delivered.
- Non-granted acks and data are forced to 0 (i_rdata, d_rdata = 0 when not acking).
- Simultaneous new requests during BUSY wait; no queuing beyond the held req lines.
- grant encoding: 2'b01 = I, 2'b10 = D; never 2'b11.

Test Plan:
1. Reset held then released with i_req=0, d_req=0 -> all outputs 0; grant=00, busy=0.
2. i_req=1, i_addr=0x100; slave acks 3 cycles after m_req with rdata=0xDEADBEEF -> m_addr=0x100 and m_size=2 one cycle after i_req; i_ack pulses 1 cycle with i_rdata=0xDEADBEEF; d_ack stays 0.
3. DATA_PRIO=1, i_req and d_req both asserted in the same cycle, each acked after 1 cycle -> D served first (grant=10), then I (grant=01); one IDLE cycle between the two transactions.
4. DATA_PRIO=0, I and D requesting continuously for 4 transactions -> grants alternate D, I, D, I (pointer starts at "I last").
5. TIMEOUT=4, d_req=1, slave never acks -> d_ack=1 and d_err=1 exactly 4 cycles after m_req rises; m_req low the next cycle; a later stray m_ack produces no ack.
6. reset asserted mid-BUSY_D -> outputs 0 immediately (asynchronously); m_ack arriving after reset release is ignored; a fresh i_req is then served normally.
